sr_latch_driver: RTL and testbench

//  Command-side driver for the gated SR latch (S, R, en inputs; Q, Qm outputs).

---
 rtl/sr_latch_driver.sv | 249 ++++++++++++++++++++++++
 tb/tb_sr_latch_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Command-side driver for a gated SR latch cell (inputs S, R, en; outputs Q,
// Qm). A one-bit set/clear request arrives over a valid/ready handshake. The
// driver then plays a glitch-free S/R/en sequence with programmable setup,
// pulse and hold lengths. It reads the latch back through two-flop
// synchronizers and finishes each request with a done pulse and an err flag.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_val    in   requested latch value (1 = set Q=1, 0 = clear Q=0)
//   req_ready  out  high only in IDLE; a transfer happens when valid & ready
//   S, R, en   out  latch drive, all registered
//   Q, Qm      in   latch outputs, asynchronous to clk
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a request completes
//   err        out  qualified by done: readback mismatch or timeout; holds
//                   its value until the next request is accepted
//
// Timing (acceptance edge ends cycle 0, defaults in brackets)
//   S/R valid from cycle 1, en high in cycles 1+SETUP .. SETUP+PULSE [3..6],
//   done in cycle SETUP+PULSE+HOLD+2 [10] for a healthy latch, or in cycle
//   SETUP+PULSE+HOLD+CHK+1 [17] on timeout.
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int SETUP_CYC = 2,   // cycles S/R settle with en=0 before en rises
    parameter int PULSE_CYC = 4,   // cycles en is held high
    parameter int HOLD_CYC  = 2,   // cycles S/R stay put after en falls
    parameter int CHK_CYC   = 8    // readback window before declaring err
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    output logic S,
    output logic R,
    output logic en,
    input  logic Q,
    input  logic Qm,
    output logic busy,
    output logic done,
    output logic err
);

    // -------------------------------------------------------------------------
    // Counter sizing: one shared down-counter, wide enough for the longest
    // phase. Each phase loads (length - 1) on entry and leaves when it hits 0.
    // -------------------------------------------------------------------------
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int MAX_CYC = max_of4(SETUP_CYC, PULSE_CYC, HOLD_CYC, CHK_CYC);
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CHK_LOAD   = CNT_W'(CHK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             tgt_q,   tgt_d;     // captured target value
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // phase down-counter

    // Registered outputs
    logic s_q,     s_d;
    logic r_q,     r_d;
    logic en_q,    en_d;
    logic ready_q, ready_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;
    logic err_q,   err_d;

    // Readback synchronizers; raw Q/Qm feed nothing else
    logic q_meta_q,  qs_q;
    logic qm_meta_q, qms_q;

    logic match;

    // -------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous latch outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta_q  <= 1'b0;
            qs_q      <= 1'b0;
            qm_meta_q <= 1'b0;
            qms_q     <= 1'b0;
        end else begin
            q_meta_q  <= Q;
            qs_q      <= q_meta_q;
            qm_meta_q <= Qm;
            qms_q     <= qm_meta_q;
        end
    end

    // A good readback needs both rails correct; Qs==Qms (both 0 or both 1)
    // can never satisfy this and is therefore treated as a mismatch.
    assign match = (qs_q == tgt_q) && (qms_q == ~tgt_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    tgt_d   = req_val;
                    err_d   = 1'b0;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = PULSE_LOAD;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = CHK_LOAD;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            CHECK: begin
                // The verdict is registered into done/err; CHECK lasts one
                // more cycle while done is visible, so req_ready only rises
                // in the cycle after done.
                if (done_q) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else if (match) begin
                    done_d = 1'b1;
                    err_d  = 1'b0;
                end else if (cnt_q == CNT_ZERO) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs line up
    // with the state register (en is high exactly while state is PULSE).
    // S/R are driven through SETUP, PULSE and HOLD and only change at the
    // IDLE->SETUP and HOLD->CHECK boundaries, where en is 0 on both sides.
    // -------------------------------------------------------------------------
    logic drive_sr;

    always_comb begin
        drive_sr = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
        s_d      = drive_sr &&  tgt_d;
        r_d      = drive_sr && !tgt_d;
        en_d     = (state_d == PULSE);
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers. The asynchronous reset drops en the instant rst_n falls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign en        = en_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
`timescale 1ns/1ps
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_val = 1'b0;
    logic req_ready, S, R, en, busy, done, err;
    logic Q, Qm;

    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .en        (en),
        .Q         (Q),
        .Qm        (Qm),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Gated SR latch model; 'stuck' forces Q=0/Qm=1 regardless of drive.
    bit lq;
    bit stuck;
    always @(S or R or en) begin
        if (en) begin
            if (S && !R)      lq = 1'b1;
            else if (R && !S) lq = 1'b0;
        end
    end
    assign Q  = stuck ? 1'b0 : lq;
    assign Qm = stuck ? 1'b1 : ~lq;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp_v, $time);
    endtask

    // Scoreboard: expected completion cycle and err per accepted request
    typedef struct {
        int   cyc;
        logic err;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit   act;
    logic act_tgt;
    int   acc_cyc;
    int   off;
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    int   viol     = 0;
    logic s_p, r_p, en_p;

    always @(negedge clk) begin
        if (rst_n) begin
            if (act) begin
                off = cyc - acc_cyc;
                if (off >= 1 && off <= 9) begin
                    check_eq("s_seq",  S,  (off <= 8) &&  act_tgt);
                    check_eq("r_seq",  R,  (off <= 8) && !act_tgt);
                    check_eq("en_seq", en, (off >= 3) && (off <= 6));
                end
                if (off >= 1) begin
                    check_eq("busy_act",  busy,      1);
                    check_eq("ready_act", req_ready, 0);
                end
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_eq("done_unexpected", done, 0);
                end else begin
                    e_mon = sb.pop_front();
                    check_eq("done_cyc", cyc, e_mon.cyc);
                    check_eq("done_err", err, e_mon.err);
                    act = 1'b0;
                end
            end
            if (req_valid && req_ready) begin
                check_eq("busy_acc", busy, 0);
                e_mon.err = stuck && req_val;
                e_mon.cyc = cyc + (e_mon.err ? 17 : 10);
                sb.push_back(e_mon);
                act     = 1'b1;
                act_tgt = req_val;
                acc_cyc = cyc;
                acc_cnt++;
            end
            // Invariants
            if (S && R) viol++;
            if ((en || (en != en_p)) && ((S != s_p) || (R != r_p))) viol++;
            if (en && !busy) viol++;
        end
        s_p  = S;
        r_p  = R;
        en_p = en;
    end

    task automatic do_req(input logic v);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_val   = v;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", (done_cnt != start), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int a0, d0;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s",     S,         0);
        check_eq("rst_r",     R,         0);
        check_eq("rst_en",    en,        0);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_busy",  busy,      0);
        check_eq("rst_done",  done,      0);
        check_eq("rst_err",   err,       0);
        rst_n = 1'b1;

        // Set
        do_req(1'b1);
        wait_done(30);
        check_eq("set_q",  Q,  1);
        check_eq("set_qm", Qm, 0);

        // Clear after set
        do_req(1'b0);
        wait_done(30);
        check_eq("clr_q",  Q,  0);
        check_eq("clr_qm", Qm, 1);

        // Stuck latch: set must time out with err
        stuck = 1'b1;
        do_req(1'b1);
        wait_done(30);
        check_eq("stuck_s",    S,    0);
        check_eq("stuck_r",    R,    0);
        check_eq("stuck_en",   en,   0);
        check_eq("stuck_err",  err,  1);
        check_eq("stuck_busy", busy, 0);
        // Stuck at 0 still satisfies a clear request
        do_req(1'b0);
        wait_done(30);
        check_eq("stuck_clr_err", err, 0);
        stuck = 1'b0;

        // Held req_valid for 30 cycles with alternating req_val
        a0 = acc_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_val   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            req_val = ~req_val;
        end
        req_valid = 1'b0;
        check_eq("held_acc", acc_cnt - a0, 3);
        wait_done(30);

        // Reset in the middle of PULSE
        do_req(1'b1);
        repeat (3) @(posedge clk);
        #3;
        check_eq("pulse_en", en, 1);
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("arst_en",    en,        0);
        check_eq("arst_s",     S,         0);
        check_eq("arst_r",     R,         0);
        check_eq("arst_ready", req_ready, 1);
        check_eq("arst_busy",  busy,      0);
        sb.delete();
        act = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("arst_no_done", done_cnt - d0, 0);
        check_eq("arst_ready2",  req_ready,     1);
        do_req(1'b0);
        wait_done(30);
        check_eq("post_rst_q", Q,   0);
        check_eq("post_rst_e", err, 0);

        check_eq("sb_empty",   sb.size(), 0);
        check_eq("invariants", viol,      0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
